coeff_wr_fsm: RTL and testbench
===============================

Name: coeff_wr_fsm

Overview:
Write-side controller for the FIR coefficient SP-SRAMs: the counterpart of the read/accumulate FSM that only reads coefficients during filtering.
- While iUpdateFlag is high, it accepts a stream of 40 coefficients over a valid/ready handshake.
- It writes them in order into the four 10-word SP-SRAM banks: bank 1 addr 0..9, then bank 2, bank 3, bank 4.
- Its chip-select/write-enable/address/data outputs feed the same access mux that selects on the current update/read state.

Parameters:
P_DW, 16, coefficient data width.
P_TAPS, 10, words per bank; last valid address is P_TAPS-1; fits the 4-bit address.
P_TOTAL, 40, coefficients per update (4 banks x P_TAPS); the bank count is fixed at 4 by the ports.

Ports:
iClk_12M  input  1  system clock, rising edge.
iRsn  input  1  reset, asynchronous, active-low.
iUpdateFlag  input  1  1'b1 = coefficient update window open; 1'b0 = filtering.
iCoeffValid  input  1  coefficient beat valid.
iCoeff  input  P_DW  coefficient data.
oCoeffReady  output  1  block can accept a beat this cycle.
oCsn_Wr_1..oCsn_Wr_4  output  1 each  bank chip select, active-low.
oWrn_Wr_1..oWrn_Wr_4  output  1 each  bank write enable, active-low.
oAddr_Wr  output  4  word address within the selected bank.
oWrDt  output  P_DW  write data.
oWrCnt  output  6  number of coefficients written in the current window (0..40).
oUpdateDone  output  1  one-cycle pulse: all 40 coefficients written.
oUpdateErr  output  1  one-cycle pulse: window closed before 40 coefficients were written.
oCurState  output  2  current state: 00 Idle, 01 Write, 10 Done.

Behaviour:
- Reset is asynchronous and active-low; all registers clear immediately on iRsn=0, independent of the clock.
  - State = Idle; oCoeffReady=0; all Csn=1 and Wrn=1; oAddr_Wr=0; oWrDt=0; oWrCnt=0; oUpdateDone=0; oUpdateErr=0.
- Handshake:
  - oCoeffReady = (state==Write) && iUpdateFlag. This is combinational and has no dependency on iCoeffValid.
  - A beat is accepted on a rising edge where iCoeffValid && oCoeffReady.
- Write timing: registered, latency 1.
  - In the cycle after an accepted beat, exactly one bank has Csn=0 and Wrn=0, with oAddr_Wr and oWrDt = the accepted beat.
  - Bank index = beat index / P_TAPS; address = beat index mod P_TAPS.
  - In every other cycle all Csn=1 and Wrn=1. oAddr_Wr and oWrDt hold their last values.
- Counters:
  - Internal address runs 0..P_TAPS-1. At P_TAPS-1 it wraps to 0 and the bank pointer (2 bits) increments.
  - oWrCnt increments per accepted beat and saturates at 40.
- States:
  - Idle -> Write when iUpdateFlag=1. Entering Write clears the address, bank pointer and oWrCnt.
  - Write -> Done on acceptance of the 40th beat. oUpdateDone pulses in the cycle after, aligned with the 40th write strobe.
  - Write -> Idle when iUpdateFlag=0 with oWrCnt<40. oUpdateErr pulses in the next cycle. Banks keep any partially written words; no rollback.
  - Done -> Idle when iUpdateFlag=0. Done -> Done otherwise; oCoeffReady=0, so extra beats are ignored and back-pressured.
  - Unused encoding 11 -> Idle.
- Simultaneous events:
  - Flag falls in the same cycle as a valid beat: ready is 0, the beat is not accepted, and the error path is taken.
  - Flag re-asserted while in Idle after an error: a new window starts from bank 1, addr 0.
- Reset during Write: any pending strobe is dropped (Csn/Wrn forced to 1 asynchronously) and the state returns to Idle.
- Back-pressure is never applied inside Write: valid beats are accepted every cycle, with no bubbles required.

Test Plan:
1. Reset: iRsn=0 mid-cycle with no clock edge -> all Csn/Wrn=1, oCoeffReady=0, oCurState=00 immediately.
2. Full update:
   - Stimulus: flag=1, 40 back-to-back beats with data 0x0100+i.
   - Required response: bank1 addr0..9 gets 0x0100..0x0109 and bank4 addr9 gets 0x0127; each strobe lags its beat by one cycle; oUpdateDone pulses once alongside the 40th strobe; oWrCnt=40; oCurState=10.
3. Gapped valid: beats with random idle cycles between them -> the same 40 writes, in order, with no strobe in gap cycles.
4. Early abort: flag drops after 13 beats -> bank2 addr2 is the last write; oUpdateErr pulses once; state 00. A new window then starts at bank1 addr0.
5. Extra beats in Done: 5 beats after the 40th -> oCoeffReady=0, no strobes, oWrCnt stays 40. Flag=0 -> state 00.
6. Reset mid-write after 7 beats -> outputs return to reset values. The next window rewrites from bank1 addr0.

Source files
------------

// File: rtl/coeff_wr_fsm.sv
// Write-side controller for the four FIR coefficient SP-SRAM banks.
// Streams P_TOTAL coefficients over valid/ready into bank 1..4, addr 0..P_TAPS-1.
module coeff_wr_fsm #(
  parameter int P_DW    = 16,
  parameter int P_TAPS  = 10,
  parameter int P_TOTAL = 40
) (
  input  logic            iClk_12M,
  input  logic            iRsn,
  input  logic            iUpdateFlag,
  input  logic            iCoeffValid,
  input  logic [P_DW-1:0] iCoeff,
  output logic            oCoeffReady,
  output logic            oCsn_Wr_1,
  output logic            oCsn_Wr_2,
  output logic            oCsn_Wr_3,
  output logic            oCsn_Wr_4,
  output logic            oWrn_Wr_1,
  output logic            oWrn_Wr_2,
  output logic            oWrn_Wr_3,
  output logic            oWrn_Wr_4,
  output logic [3:0]      oAddr_Wr,
  output logic [P_DW-1:0] oWrDt,
  output logic [5:0]      oWrCnt,
  output logic            oUpdateDone,
  output logic            oUpdateErr,
  output logic [1:0]      oCurState
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WRITE = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      addr_q, addr_d;
  logic [1:0]      bank_q, bank_d;
  logic [5:0]      wrcnt_q, wrcnt_d;
  logic [3:0]      csn_q, csn_d;
  logic [3:0]      wrn_q, wrn_d;
  logic [3:0]      addr_wr_q, addr_wr_d;
  logic [P_DW-1:0] wrdt_q, wrdt_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic ready;
  logic accept;
  logic last_beat;

  assign ready     = (state_q == S_WRITE) && iUpdateFlag;
  assign accept    = ready && iCoeffValid;
  assign last_beat = (wrcnt_q == 6'(P_TOTAL - 1));

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      bank_q    <= '0;
      wrcnt_q   <= '0;
      csn_q     <= '1;
      wrn_q     <= '1;
      addr_wr_q <= '0;
      wrdt_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      bank_q    <= bank_d;
      wrcnt_q   <= wrcnt_d;
      csn_q     <= csn_d;
      wrn_q     <= wrn_d;
      addr_wr_q <= addr_wr_d;
      wrdt_q    <= wrdt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = iUpdateFlag ? S_WRITE : S_IDLE;
      S_WRITE: begin
        if (!iUpdateFlag)             state_d = S_IDLE;
        else if (accept && last_beat) state_d = S_DONE;
        else                          state_d = S_WRITE;
      end
      S_DONE:  state_d = iUpdateFlag ? S_DONE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    bank_d    = bank_q;
    wrcnt_d   = wrcnt_q;
    csn_d     = '1;
    wrn_d     = '1;
    addr_wr_d = addr_wr_q;
    wrdt_d    = wrdt_q;
    done_d    = 1'b0;
    err_d     = (state_q == S_WRITE) && !iUpdateFlag && (wrcnt_q < 6'(P_TOTAL));
    if ((state_q == S_IDLE) && iUpdateFlag) begin
      addr_d  = '0;
      bank_d  = '0;
      wrcnt_d = '0;
    end
    // Strobe is registered: the accepted beat appears on the bank pins next cycle.
    if (accept) begin
      csn_d[bank_q] = 1'b0;
      wrn_d[bank_q] = 1'b0;
      addr_wr_d     = addr_q;
      wrdt_d        = iCoeff;
      done_d        = last_beat;
      if (addr_q == 4'(P_TAPS - 1)) begin
        addr_d = '0;
        bank_d = bank_q + 2'd1;
      end else begin
        addr_d = addr_q + 4'd1;
      end
      if (wrcnt_q != 6'(P_TOTAL)) wrcnt_d = wrcnt_q + 6'd1;
    end
  end

  assign oCoeffReady = ready;
  assign oCsn_Wr_1   = csn_q[0];
  assign oCsn_Wr_2   = csn_q[1];
  assign oCsn_Wr_3   = csn_q[2];
  assign oCsn_Wr_4   = csn_q[3];
  assign oWrn_Wr_1   = wrn_q[0];
  assign oWrn_Wr_2   = wrn_q[1];
  assign oWrn_Wr_3   = wrn_q[2];
  assign oWrn_Wr_4   = wrn_q[3];
  assign oAddr_Wr    = addr_wr_q;
  assign oWrDt       = wrdt_q;
  assign oWrCnt      = wrcnt_q;
  assign oUpdateDone = done_q;
  assign oUpdateErr  = err_q;
  assign oCurState   = state_q;

endmodule

// File: tb/tb_coeff_wr_fsm.sv
// Directed bench for coeff_wr_fsm: full, gapped, aborted, over-fed and reset-interrupted windows.
module tb_coeff_wr_fsm;

  logic        clk = 1'b0;
  logic        rsn;
  logic        flag;
  logic        valid;
  logic [15:0] coeff;
  logic        ready;
  logic        csn1, csn2, csn3, csn4;
  logic        wrn1, wrn2, wrn3, wrn4;
  logic [3:0]  addr;
  logic [15:0] wrdt;
  logic [5:0]  wrcnt;
  logic        done;
  logic        err;
  logic [1:0]  cstate;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  coeff_wr_fsm #(.P_DW(16), .P_TAPS(10), .P_TOTAL(40)) dut (
    .iClk_12M   (clk),
    .iRsn       (rsn),
    .iUpdateFlag(flag),
    .iCoeffValid(valid),
    .iCoeff     (coeff),
    .oCoeffReady(ready),
    .oCsn_Wr_1  (csn1),
    .oCsn_Wr_2  (csn2),
    .oCsn_Wr_3  (csn3),
    .oCsn_Wr_4  (csn4),
    .oWrn_Wr_1  (wrn1),
    .oWrn_Wr_2  (wrn2),
    .oWrn_Wr_3  (wrn3),
    .oWrn_Wr_4  (wrn4),
    .oAddr_Wr   (addr),
    .oWrDt      (wrdt),
    .oWrCnt     (wrcnt),
    .oUpdateDone(done),
    .oUpdateErr (err),
    .oCurState  (cstate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {25'd0, ready, csn4, csn3, csn2, csn1, wrn4, wrn3, wrn2, wrn1,
            addr, wrdt, wrcnt, done, err, cstate};
  endfunction

  function automatic logic [63:0] strobe_view();
    return {35'd0, csn4, csn3, csn2, csn1, wrn4, wrn3, wrn2, wrn1, addr, wrdt, done};
  endfunction

  // Expected bank-pin picture one cycle after beat idx with data d.
  function automatic logic [63:0] strobe_exp(input int idx, input logic [15:0] d);
    logic [3:0] sel;
    logic [3:0] a;
    sel = ~(4'b0001 << (idx / 10));
    a   = 4'(idx % 10);
    return {35'd0, sel, sel, a, d, (idx == 39)};
  endfunction

  task automatic beat(input int idx, input logic [15:0] d);
    valid = 1'b1;
    coeff = d;
    #1;
    chk("ready_in_write", {63'd0, ready}, 64'd1);
    step();
    valid = 1'b0;
    chk($sformatf("strobe_%0d", idx), strobe_view(), strobe_exp(idx, d));
  endtask

  task automatic idle_cycle_check(input string tag);
    step();
    chk(tag, {56'd0, csn4, csn3, csn2, csn1, wrn4, wrn3, wrn2, wrn1}, {56'd0, 8'hFF});
  endtask

  localparam logic [63:0] RESET_VIEW = {25'd0, 1'b0, 4'hF, 4'hF, 4'h0, 16'h0, 6'd0, 1'b0, 1'b0, 2'b00};

  initial begin
    rsn   = 1'b0;
    flag  = 1'b0;
    valid = 1'b0;
    coeff = '0;
    #12;
    chk("reset_initial", all_outs(), RESET_VIEW);
    step();
    rsn = 1'b1;
    step();

    // Asynchronous reset between edges with a strobe on the pins.
    flag = 1'b1;
    step();
    beat(0, 16'h5A5A);
    #3;
    rsn = 1'b0;
    #1;
    chk("async_reset", all_outs(), RESET_VIEW);
    step();
    rsn = 1'b1;

    // Full back-to-back window.
    step();
    chk("enter_write", {62'd0, cstate}, 64'd1);
    for (int i = 0; i < 40; i++) beat(i, 16'h0100 + 16'(i));
    chk("full_cnt_state", {56'd0, wrcnt, cstate}, {56'd0, 6'd40, 2'b10});
    idle_cycle_check("after_full_quiet");
    chk("done_single_pulse", {63'd0, done}, 64'd0);

    // Extra beats in Done are back-pressured.
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      coeff = 16'hDEAD;
      #1;
      chk("done_ready_low", {63'd0, ready}, 64'd0);
      idle_cycle_check("done_no_strobe");
      chk("done_cnt_hold", {58'd0, wrcnt}, 64'd40);
    end
    valid = 1'b0;
    flag  = 1'b0;
    step();
    chk("done_to_idle", {61'd0, err, cstate}, 64'd0);

    // Gapped window.
    flag = 1'b1;
    step();
    for (int i = 0; i < 40; i++) begin
      beat(i, 16'h2000 + 16'(i));
      for (int g = 0; g < (i % 3); g++) idle_cycle_check("gap_no_strobe");
    end
    chk("gap_cnt_state", {56'd0, wrcnt, cstate}, {56'd0, 6'd40, 2'b10});
    flag = 1'b0;
    step();

    // Early abort after 13 beats, flag dropping alongside a valid beat.
    flag = 1'b1;
    step();
    for (int i = 0; i < 13; i++) beat(i, 16'h3000 + 16'(i));
    flag  = 1'b0;
    valid = 1'b1;
    coeff = 16'hBEEF;
    #1;
    chk("abort_ready_low", {63'd0, ready}, 64'd0);
    step();
    valid = 1'b0;
    chk("abort_view", {48'd0, csn4, csn3, csn2, csn1, wrcnt, err, done, cstate},
        {48'd0, 4'hF, 6'd13, 1'b1, 1'b0, 2'b00});
    step();
    chk("abort_err_single", {63'd0, err}, 64'd0);
    flag = 1'b1;
    step();
    chk("restart_cnt_clear", {58'd0, wrcnt}, 64'd0);
    beat(0, 16'hAAAA);
    beat(1, 16'hAAAB);

    // Reset mid-write after 7 beats, then rewrite from bank 1 addr 0.
    for (int i = 2; i < 7; i++) beat(i, 16'h4000 + 16'(i));
    valid = 1'b1;
    coeff = 16'h4007;
    #3;
    rsn = 1'b0;
    #1;
    chk("midwrite_reset", all_outs(), RESET_VIEW);
    valid = 1'b0;
    step();
    rsn = 1'b1;
    step();
    chk("post_reset_write", {62'd0, cstate}, 64'd1);
    beat(0, 16'h7777);
    chk("post_reset_cnt", {58'd0, wrcnt}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
